// File: rtl/menu_selector_if.sv
// Menu stage bus: raw buttons and chain handshakes in, menu outputs back out.
interface menu_selector_if #(
    parameter int unsigned N_OPT = 4
);
    localparam int unsigned IDX_W = (N_OPT > 1) ? $clog2(N_OPT) : 1;

    logic             btn_next;
    logic             btn_prev;
    logic             btn_sel;
    logic             btn_cancel;
    logic             act_in;
    logic             back_in;
    logic [N_OPT-1:0] opt_onehot;
    logic [IDX_W-1:0] choice;
    logic             act_out;
    logic             cancel_out;
    logic             busy;

    modport master (
        output btn_next, btn_prev, btn_sel, btn_cancel, act_in, back_in,
        input  opt_onehot, choice, act_out, cancel_out, busy
    );

    modport slave (
        input  btn_next, btn_prev, btn_sel, btn_cancel, act_in, back_in,
        output opt_onehot, choice, act_out, cancel_out, busy
    );
endinterface

// File: rtl/menu_selector.sv
// Parametrised menu stage: button sync/debounce/edge detect, wrap-around browsing,
// confirm and back/cancel handshake with neighbouring stages.
// Optional feature macro: MENU_TIMEOUT_EN (BROWSE inactivity timeout).
module menu_selector #(
    parameter int unsigned N_OPT       = 4,
    parameter int unsigned DEB_CYC     = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic            clk,
    input  logic            reset,
    menu_selector_if.slave  bus
);
    localparam int unsigned IDX_W    = (N_OPT > 1) ? $clog2(N_OPT) : 1;
    localparam int unsigned CNT_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int unsigned N_BTN    = 4;
    localparam int unsigned B_NEXT   = 0;
    localparam int unsigned B_PREV   = 1;
    localparam int unsigned B_SEL    = 2;
    localparam int unsigned B_CANCEL = 3;

    // Elaboration-time guard on the supported parameter range.
    if (N_OPT < 2 || N_OPT > 16 || DEB_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_err
        $error("menu_selector: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BROWSE,
        ST_CONFIRMED
    } state_t;

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_s1;
    logic [N_BTN-1:0] btn_s2;
    logic [N_BTN-1:0] btn_deb;
    logic [N_BTN-1:0] btn_evt;
    logic [CNT_W-1:0] deb_cnt [N_BTN];

    logic act_s1;
    logic act_s2;
    logic act_d;
    logic act_rise;
    logic act_fall;

    state_t           state;
    state_t           state_n;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_n;
    logic [IDX_W-1:0] choice_n;
    logic             cancel_n;
    logic [N_OPT-1:0] onehot_n;

`ifdef MENU_TIMEOUT_EN
    localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_n;
`endif

    assign btn_raw  = {bus.btn_cancel, bus.btn_sel, bus.btn_prev, bus.btn_next};
    assign act_rise = act_s2 & ~act_d;
    assign act_fall = ~act_s2 & act_d;

    // Synchronise and debounce the buttons; emit a 1-cycle event on each accepted press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1  <= '0;
            btn_s2  <= '0;
            btn_deb <= '0;
            btn_evt <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            for (int i = 0; i < int'(N_BTN); i++) begin
                if (btn_s2[i] != btn_deb[i]) begin
                    if (deb_cnt[i] == CNT_W'(DEB_CYC - 1)) begin
                        btn_deb[i] <= btn_s2[i];
                        btn_evt[i] <= btn_s2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        btn_evt[i] <= 1'b0;
                        deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    btn_evt[i] <= 1'b0;
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Synchronise act_in and keep the previous level for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_s1 <= 1'b0;
            act_s2 <= 1'b0;
            act_d  <= 1'b0;
        end else begin
            act_s1 <= bus.act_in;
            act_s2 <= act_s1;
            act_d  <= act_s2;
        end
    end

    // State, index and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            idx            <= '0;
            bus.choice     <= '0;
            bus.opt_onehot <= '0;
            bus.act_out    <= 1'b0;
            bus.cancel_out <= 1'b0;
            bus.busy       <= 1'b0;
`ifdef MENU_TIMEOUT_EN
            tmr            <= '0;
`endif
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            bus.choice     <= choice_n;
            bus.opt_onehot <= onehot_n;
            bus.act_out    <= (state_n == ST_CONFIRMED);
            bus.cancel_out <= cancel_n;
            bus.busy       <= (state_n == ST_BROWSE);
`ifdef MENU_TIMEOUT_EN
            tmr            <= tmr_n;
`endif
        end
    end

    // Next state: upstream activity first, then cancel > sel > next/prev.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        choice_n = bus.choice;
        cancel_n = 1'b0;
`ifdef MENU_TIMEOUT_EN
        tmr_n    = tmr;
`endif
        case (state)
            ST_IDLE: begin
                if (act_rise) begin
                    state_n = ST_BROWSE;
                    idx_n   = '0;
`ifdef MENU_TIMEOUT_EN
                    tmr_n   = '0;
`endif
                end
            end
            ST_BROWSE: begin
                if (act_fall) begin
                    state_n  = ST_IDLE;
                    idx_n    = '0;
                    choice_n = '0;
                end else if (act_rise) begin
                    idx_n = '0;
`ifdef MENU_TIMEOUT_EN
                    tmr_n = '0;
`endif
                end else if (btn_evt[B_CANCEL]) begin
                    state_n  = ST_IDLE;
                    idx_n    = '0;
                    choice_n = '0;
                    cancel_n = 1'b1;
                end else if (btn_evt[B_SEL]) begin
                    state_n  = ST_CONFIRMED;
                    choice_n = idx;
                end else if (btn_evt[B_NEXT] || btn_evt[B_PREV]) begin
                    if (btn_evt[B_NEXT] && !btn_evt[B_PREV]) begin
                        idx_n = (idx == IDX_W'(N_OPT - 1)) ? '0 : idx + IDX_W'(1);
                    end else if (btn_evt[B_PREV] && !btn_evt[B_NEXT]) begin
                        idx_n = (idx == '0) ? IDX_W'(N_OPT - 1) : idx - IDX_W'(1);
                    end
`ifdef MENU_TIMEOUT_EN
                    tmr_n = '0;
`endif
                end
`ifdef MENU_TIMEOUT_EN
                else if (tmr == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_n  = ST_IDLE;
                    idx_n    = '0;
                    choice_n = '0;
                    cancel_n = 1'b1;
                    tmr_n    = '0;
                end else begin
                    tmr_n = tmr + TMR_W'(1);
                end
`endif
            end
            ST_CONFIRMED: begin
                if (act_fall) begin
                    state_n  = ST_IDLE;
                    idx_n    = '0;
                    choice_n = '0;
                end else if (act_rise) begin
                    state_n = ST_BROWSE;
                    idx_n   = '0;
`ifdef MENU_TIMEOUT_EN
                    tmr_n   = '0;
`endif
                end else if (bus.back_in) begin
                    state_n = ST_BROWSE;
                    idx_n   = bus.choice;
`ifdef MENU_TIMEOUT_EN
                    tmr_n   = '0;
`endif
                end
            end
            default: begin
                state_n  = ST_IDLE;
                idx_n    = '0;
                choice_n = '0;
            end
        endcase

        if (state_n == ST_BROWSE) begin
            onehot_n = N_OPT'(1) << idx_n;
        end else if (state_n == ST_CONFIRMED) begin
            onehot_n = N_OPT'(1) << choice_n;
        end else begin
            onehot_n = '0;
        end
    end
endmodule

// File: tb/tb_menu_selector.sv
// Randomised bench for menu_selector against an action-level reference model.
module tb_menu_selector;
    localparam int N_OPT   = 5;
    localparam int DEB     = 2;
    localparam int TIMEOUT = 20;

    localparam int M_IDLE = 0;
    localparam int M_BROWSE = 1;
    localparam int M_CONF = 2;

    localparam int A_NEXT = 0, A_PREV = 1, A_BOTH = 2, A_SEL = 3, A_BACK = 4;
    localparam int A_CANCEL = 5, A_GLITCH = 6, A_RESTART = 7, A_WITHDRAW = 8, A_SELCAN = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int cancel_cycles = 0;
    int exp_cancel = 0;

    int m_state = M_IDLE;
    int m_idx = 0;
    int m_choice = 0;

    menu_selector_if #(.N_OPT(N_OPT)) bus ();

    menu_selector #(
        .N_OPT(N_OPT),
        .DEB_CYC(DEB),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Count cycles with cancel_out high; each cancel must add exactly one.
    always @(negedge clk) begin
        if (bus.cancel_out) cancel_cycles <= cancel_cycles + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] exp_oh;
        if (m_state == M_BROWSE)    exp_oh = 32'(1) << m_idx;
        else if (m_state == M_CONF) exp_oh = 32'(1) << m_choice;
        else                        exp_oh = 32'd0;
        check({tag, "_onehot"}, 32'(bus.opt_onehot), exp_oh);
        check({tag, "_busy"},   32'(bus.busy), 32'(m_state == M_BROWSE));
        check({tag, "_act"},    32'(bus.act_out), 32'(m_state == M_CONF));
        check({tag, "_cancel"}, 32'(cancel_cycles), 32'(exp_cancel));
        if (m_state == M_CONF) check({tag, "_choice"}, 32'(bus.choice), 32'(m_choice));
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        @(negedge clk);
        {bus.btn_cancel, bus.btn_sel, bus.btn_prev, bus.btn_next} = m;
        repeat (hold) @(negedge clk);
        {bus.btn_cancel, bus.btn_sel, bus.btn_prev, bus.btn_next} = 4'b0000;
        repeat (6) @(negedge clk);
    endtask

    // Perform one user/chain action and update the model from the menu rules.
    task automatic do_action(input int a, input int hold);
        case (a)
            A_NEXT: begin
                press(4'b0001, hold);
                if (m_state == M_BROWSE) m_idx = (m_idx + 1) % N_OPT;
            end
            A_PREV: begin
                press(4'b0010, hold);
                if (m_state == M_BROWSE) m_idx = (m_idx + N_OPT - 1) % N_OPT;
            end
            A_BOTH: press(4'b0011, hold);
            A_SEL: begin
                press(4'b0100, hold);
                if (m_state == M_BROWSE) begin
                    m_state = M_CONF;
                    m_choice = m_idx;
                end
            end
            A_CANCEL, A_SELCAN: begin
                press((a == A_CANCEL) ? 4'b1000 : 4'b1100, hold);
                if (m_state == M_BROWSE) begin
                    m_state = M_IDLE;
                    m_idx = 0;
                    exp_cancel++;
                end
            end
            A_BACK: begin
                @(negedge clk);
                bus.back_in = 1'b1;
                @(negedge clk);
                bus.back_in = 1'b0;
                repeat (3) @(negedge clk);
                if (m_state == M_CONF) begin
                    m_state = M_BROWSE;
                    m_idx = m_choice;
                end
            end
            A_GLITCH: begin
                @(negedge clk);
                bus.btn_next = 1'b1;
                @(negedge clk);
                bus.btn_next = 1'b0;
                repeat (6) @(negedge clk);
            end
            A_RESTART: begin
                bus.act_in = 1'b0;
                repeat (4) @(negedge clk);
                bus.act_in = 1'b1;
                repeat (5) @(negedge clk);
                m_state = M_BROWSE;
                m_idx = 0;
            end
            A_WITHDRAW: begin
                bus.act_in = 1'b0;
                repeat (5) @(negedge clk);
                m_state = M_IDLE;
                m_idx = 0;
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [4:0] steps [5];
        int hold;
        steps[0] = 5'b00010; steps[1] = 5'b00100; steps[2] = 5'b01000;
        steps[3] = 5'b10000; steps[4] = 5'b00001;
        hold = DEB + 2;

        bus.btn_next = 1'b0; bus.btn_prev = 1'b0; bus.btn_sel = 1'b0;
        bus.btn_cancel = 1'b0; bus.act_in = 1'b0; bus.back_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs("reset");
        check("reset_choice", 32'(bus.choice), 32'd0);

        do_action(A_RESTART, hold);
        check("activate_onehot", 32'(bus.opt_onehot), 32'b00001);

        // Wrap-around browsing forward, then backward from index 0.
        for (int i = 0; i < 5; i++) begin
            do_action(A_NEXT, hold);
            check("next_step", 32'(bus.opt_onehot), 32'(steps[i]));
        end
        do_action(A_PREV, hold);
        check("prev_wrap", 32'(bus.opt_onehot), 32'b10000);

        // Asynchronous reset mid-browse at index 3.
        do_action(A_NEXT, hold);
        for (int i = 0; i < 3; i++) do_action(A_NEXT, hold);
        check("idx3_onehot", 32'(bus.opt_onehot), 32'b01000);
        @(negedge clk);
        #2;
        rst = 1'b1;
        bus.act_in = 1'b0;
        #1;
        m_state = M_IDLE; m_idx = 0;
        check("async_rst_onehot", 32'(bus.opt_onehot), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_choice", 32'(bus.choice), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        do_action(A_RESTART, hold);
        check("rst_reactivate", 32'(bus.opt_onehot), 32'b00001);

        // Short glitch gives no move; a long hold gives exactly one step.
        do_action(A_GLITCH, hold);
        check("glitch_onehot", 32'(bus.opt_onehot), 32'b00001);
`ifdef MENU_TIMEOUT_EN
        do_action(A_NEXT, 15);
`else
        do_action(A_NEXT, 50);
`endif
        check("long_hold", 32'(bus.opt_onehot), 32'b00010);

        // Confirm index 2, then reopen via back_in.
        do_action(A_NEXT, hold);
        do_action(A_SEL, hold);
        check("sel_act", 32'(bus.act_out), 32'd1);
        check("sel_choice", 32'(bus.choice), 32'd2);
        check_outputs("sel");
        do_action(A_NEXT, hold);
        check_outputs("conf_ignores_btn");
        do_action(A_BACK, hold);
        check("back_onehot", 32'(bus.opt_onehot), 32'b00100);
        check_outputs("back");

        // sel and cancel together: cancel wins.
        do_action(A_SELCAN, hold);
        check("selcan_act", 32'(bus.act_out), 32'd0);
        check_outputs("selcan");

        // next and prev together: no move.
        do_action(A_RESTART, hold);
        do_action(A_NEXT, hold);
        do_action(A_BOTH, hold);
        check("both_onehot", 32'(bus.opt_onehot), 32'b00010);

        // Upstream withdraws: idle without a cancel pulse.
        do_action(A_WITHDRAW, hold);
        check_outputs("withdraw");

        // Inactivity behaviour in BROWSE.
        do_action(A_RESTART, hold);
`ifdef MENU_TIMEOUT_EN
        repeat (TIMEOUT + 5) @(negedge clk);
        m_state = M_IDLE; m_idx = 0; exp_cancel++;
        check_outputs("timeout");
`else
        repeat (200) @(negedge clk);
        check_outputs("no_timeout");
`endif

        // Random action sequence against the model.
        for (int k = 0; k < 150; k++) begin
            int a;
            a = $urandom_range(0, 9);
            if (m_state == M_IDLE) a = A_RESTART;
`ifdef MENU_TIMEOUT_EN
            if (m_state == M_BROWSE && (a == A_BACK || a == A_GLITCH || a == A_WITHDRAW)) a = A_NEXT;
`endif
            do_action(a, DEB + 2 + int'($urandom_range(0, 2)));
            check_outputs("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
